// File: rtl/reg_file_pkg.sv
// Shared register-file definitions: default geometry and the scanner state encoding.
package reg_file_pkg;

  localparam int RF_DATA_WIDTH = 8;
  localparam int RF_ADDR_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } scan_state_e;

endpackage

// File: rtl/reg_file_scanner.sv
// Walks the register-file read port over a contiguous address range and streams each
// entry out on a valid/ready interface with its address, a last flag and an XOR checksum.
module reg_file_scanner
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_last,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_CNT   = (ADDR_WIDTH+1)'(1);

  scan_state_e           state_q, state_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  load;

  assign accept = m_valid_q && m_ready;
  // The output register may refill whenever it is empty or being drained this cycle.
  assign load   = (state_q == ST_RUN) && (rem_q != '0) && (!m_valid_q || m_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      rd_addr_q  <= '0;
      m_addr_q   <= '0;
      m_data_q   <= '0;
      checksum_q <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      rd_addr_q  <= rd_addr_d;
      m_addr_q   <= m_addr_d;
      m_data_q   <= m_data_d;
      checksum_q <= checksum_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    rd_addr_d  = rd_addr_q;
    m_addr_d   = m_addr_q;
    m_data_d   = m_data_q;
    checksum_d = checksum_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    done_d     = 1'b0;

    if (accept) begin
      checksum_d = checksum_q ^ m_data_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rd_addr_d  = base_addr;
          rem_d      = (count > DEPTH_CNT) ? DEPTH_CNT : count;
          checksum_d = '0;
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (load) begin
          m_data_d  = rd_data;
          m_addr_d  = rd_addr_q;
          m_last_d  = (rem_q == ONE_CNT);
          m_valid_d = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          rem_d     = rem_q - ONE_CNT;
          if (rem_q == ONE_CNT) begin
            state_d = ST_FLUSH;
          end
        end else if (accept) begin
          m_valid_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (accept) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign rd_addr  = rd_addr_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_addr   = m_addr_q;
  assign m_last   = m_last_q;
  assign done     = done_q;
  assign checksum = checksum_q;

endmodule
